ws281x_frame_sequencer: RTL

Frame-level transmit controller for the WS281X pixel stream. It pulls 24-bit RGB words from an upstream source over a valid/ready handshake and serialises each word MSB-first into the three-phase WS281X bit waveform: high, data, low. After the requested pixel count it appends the latch gap. It sits between the pixel buffer and the output pin, and it generates the same stream that WS281X_Breakout consumes.

---
 rtl/ws281x_pkg.sv | 23 ++
 rtl/ws281x_phase_timer.sv | 41 ++++
 rtl/ws281x_frame_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ws281x_pkg.sv
// Shared timing defaults, state encoding and helpers for the WS281X frame sequencer.
package ws281x_pkg;

    localparam int unsigned T_HIGH         = 13;
    localparam int unsigned T_DATA         = 19;
    localparam int unsigned T_LOW          = 31;
    localparam int unsigned LATCH_CYC      = 2600;
    localparam int unsigned BITS_PER_PIXEL = 24;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StHigh,
        StData,
        StLow,
        StLatch
    } state_e;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ws281x_phase_timer.sv
// Loadable down-counter; tc pulses for one cycle when a loaded count has run out.
module ws281x_phase_timer #(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             running_q, running_d;

    // A phase of D cycles is loaded with D-1; tc marks its last cycle.
    assign tc = running_q && (cnt_q == '0);

    always_comb begin
        cnt_d     = cnt_q;
        running_d = running_q;
        if (load) begin
            cnt_d     = load_val;
            running_d = 1'b1;
        end else if (tc) begin
            running_d = 1'b0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            running_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            running_q <= running_d;
        end
    end

endmodule

// File: rtl/ws281x_frame_sequencer.sv
// Pulls RGB words over valid/ready and serialises them MSB-first into the WS281X
// high/data/low bit waveform, followed by the latch gap.
module ws281x_frame_sequencer #(
    parameter int unsigned T_HIGH    = ws281x_pkg::T_HIGH,
    parameter int unsigned T_DATA    = ws281x_pkg::T_DATA,
    parameter int unsigned T_LOW     = ws281x_pkg::T_LOW,
    parameter int unsigned LATCH_CYC = ws281x_pkg::LATCH_CYC,
    parameter int unsigned PIX_W     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PIX_W-1:0] num_pixels,
    input  logic [23:0]      pixel_data,
    input  logic             pixel_valid,
    output logic             pixel_ready,
    output logic             dout,
    output logic             busy,
    output logic             done,
    output logic             underrun,
    output logic [PIX_W-1:0] pixel_index
);

    import ws281x_pkg::*;

    localparam int unsigned CNT_W =
        $clog2(max2(max2(T_HIGH, T_DATA), max2(T_LOW, LATCH_CYC)) + 1);
    localparam logic [4:0] LAST_BIT = 5'(BITS_PER_PIXEL - 1);

    state_e                    state_q, state_d;
    logic [BITS_PER_PIXEL-1:0] shift_q, shift_d;
    logic [BITS_PER_PIXEL-1:0] hold_q, hold_d;
    logic                      hold_full_q, hold_full_d;
    logic [4:0]                bit_q, bit_d;
    logic [PIX_W-1:0]          num_q, num_d;
    logic [PIX_W-1:0]          fetched_q, fetched_d;
    logic [PIX_W-1:0]          idx_q, idx_d;
    logic [PIX_W-1:0]          idx_inc;
    logic                      underrun_q, underrun_d;
    logic                      done_q, done_d;
    logic                      dout_q, dout_d;
    logic                      accept;
    logic                      timer_load;
    logic [CNT_W-1:0]          timer_val;
    logic                      timer_tc;

    ws281x_phase_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .tc       (timer_tc)
    );

    assign busy        = (state_q != StIdle);
    assign pixel_ready = busy && !hold_full_q && (fetched_q < num_q);
    assign accept      = pixel_ready && pixel_valid;
    assign idx_inc     = idx_q + PIX_W'(1);

    assign dout        = dout_q;
    assign done        = done_q;
    assign underrun    = underrun_q;
    assign pixel_index = idx_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        bit_d       = bit_q;
        num_d       = num_q;
        fetched_d   = fetched_q;
        idx_d       = idx_q;
        underrun_d  = underrun_q;
        done_d      = 1'b0;
        timer_load  = 1'b0;
        timer_val   = '0;

        // Load and accept never coincide: accept needs the holding register empty.
        if (accept) begin
            hold_d      = pixel_data;
            hold_full_d = 1'b1;
            fetched_d   = fetched_q + PIX_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    num_d       = num_pixels;
                    underrun_d  = 1'b0;
                    fetched_d   = '0;
                    idx_d       = '0;
                    bit_d       = '0;
                    hold_full_d = 1'b0;
                    if (num_pixels != '0) begin
                        state_d = StWait;
                    end else begin
                        state_d    = StLatch;
                        timer_load = 1'b1;
                        timer_val  = CNT_W'(LATCH_CYC - 1);
                    end
                end
            end
            StWait: begin
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    bit_d       = '0;
                    state_d     = StHigh;
                    timer_load  = 1'b1;
                    timer_val   = CNT_W'(T_HIGH - 1);
                end
            end
            StHigh: begin
                if (timer_tc) begin
                    state_d    = StData;
                    timer_load = 1'b1;
                    timer_val  = CNT_W'(T_DATA - 1);
                end
            end
            StData: begin
                if (timer_tc) begin
                    state_d    = StLow;
                    timer_load = 1'b1;
                    timer_val  = CNT_W'(T_LOW - 1);
                end
            end
            StLow: begin
                if (timer_tc) begin
                    shift_d = shift_q << 1;
                    bit_d   = bit_q + 5'd1;
                    if (bit_q != LAST_BIT) begin
                        state_d    = StHigh;
                        timer_load = 1'b1;
                        timer_val  = CNT_W'(T_HIGH - 1);
                    end else if (idx_inc == num_q) begin
                        state_d    = StLatch;
                        timer_load = 1'b1;
                        timer_val  = CNT_W'(LATCH_CYC - 1);
                    end else if (hold_full_q) begin
                        // Next word already waiting: continue with no gap.
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        bit_d       = '0;
                        idx_d       = idx_inc;
                        state_d     = StHigh;
                        timer_load  = 1'b1;
                        timer_val   = CNT_W'(T_HIGH - 1);
                    end else begin
                        idx_d      = idx_inc;
                        underrun_d = 1'b1;
                        state_d    = StWait;
                    end
                end
            end
            StLatch: begin
                if (timer_tc) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Pin value follows the next state so the flop output lines up with the phase.
        dout_d = (state_d == StHigh) || ((state_d == StData) && shift_d[BITS_PER_PIXEL-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bit_q       <= '0;
            num_q       <= '0;
            fetched_q   <= '0;
            idx_q       <= '0;
            underrun_q  <= 1'b0;
            done_q      <= 1'b0;
            dout_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            bit_q       <= bit_d;
            num_q       <= num_d;
            fetched_q   <= fetched_d;
            idx_q       <= idx_d;
            underrun_q  <= underrun_d;
            done_q      <= done_d;
            dout_q      <= dout_d;
        end
    end

endmodule
